// File: rtl/lane_spawner.sv
// lane_spawner: per-lane traffic scheduler for one road lane.
//
// Decides when a new car enters the lane. On a spawn it takes the
// lowest-index free car slot and gives it a pseudo-random car type.
// It drives each slot's spawn enable and type, plus the lane-wide
// speed, direction and spawn row. Everything advances once per video
// frame on FrameClk.
//
// Parameters:
//   NumSlots  - car instances owned by this lane (1..8)
//   LaneY     - pixel row driven on SpawnY
//   LaneLeft  - direction driven on FaceLeft
//   LaneSpeed - speed driven on Speed (common to the lane)
//   MinGap    - minimum frames between spawns (>= 1)
//   Seed      - LFSR reset value (nonzero)
//
// Ports:
//   FrameClk    in   1           frame clock, sole clock
//   ResetN      in   1           asynchronous active-low reset
//   Run         in   1           gameplay active; low stops and clears the lane
//   CarExit     in   NumSlots    per-slot one-frame pulse: car left the screen
//   SpawnEnable out  NumSlots    slot occupied and drawn
//   CarType     out  2*NumSlots  slot i type at [2i+1:2i], values 0..2
//   Speed       out  3           constant LaneSpeed
//   FaceLeft    out  1           constant LaneLeft
//   SpawnY      out  10          constant LaneY
//   LaneFull    out  1           high while every slot is taken and a spawn is pending
//
// Build option:
//   LANE_SPAWNER_JITTER_EN - when defined, each gap is MinGap + lfsr[7:2]
//                            (MinGap..MinGap+63). When undefined, each gap
//                            is exactly MinGap.
module lane_spawner #(
  parameter int unsigned NumSlots  = 4,
  parameter logic [9:0]  LaneY     = 10'd0,
  parameter logic        LaneLeft  = 1'b0,
  parameter logic [2:0]  LaneSpeed = 3'd2,
  parameter logic [7:0]  MinGap    = 8'd40,
  parameter logic [15:0] Seed      = 16'hACE1
) (
  input  logic                    FrameClk,
  input  logic                    ResetN,
  input  logic                    Run,
  input  logic [NumSlots-1:0]     CarExit,
  output logic [NumSlots-1:0]     SpawnEnable,
  output logic [2*NumSlots-1:0]   CarType,
  output logic [2:0]              Speed,
  output logic                    FaceLeft,
  output logic [9:0]              SpawnY,
  output logic                    LaneFull
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSpawn   = 2'd1;
  localparam logic [1:0] StGap     = 2'd2;
  localparam logic [1:0] StBlocked = 2'd3;

  // Galois LFSR, x^16+x^14+x^13+x^11, right-shifting form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {1'b0, cur[15:1]} ^ ({16{cur[0]}} & 16'hB400);
  endfunction

  // Only three car types exist; the fourth LFSR code folds onto type 0.
  function automatic logic [1:0] remap_type(input logic [1:0] raw);
    remap_type = (raw == 2'b11) ? 2'b00 : raw;
  endfunction

  logic [1:0]              state;
  logic [15:0]             lfsr;
  logic [8:0]              gap_cnt;
  logic [NumSlots-1:0]     occ;
  logic [2*NumSlots-1:0]   types;
  logic                    full;

  logic                    found;
  logic [NumSlots-1:0]     pick;
  logic [1:0]              new_type;
  logic [8:0]              gap_value;

  // Lowest-index free slot, one-hot. The search looks at the registered
  // occupancy, so a car exiting on this edge is not reusable until the next.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (!found && !occ[i]) begin
        found   = 1'b1;
        pick[i] = 1'b1;
      end
    end
  end

  assign new_type = remap_type(lfsr[1:0]);

`ifdef LANE_SPAWNER_JITTER_EN
  assign gap_value = {1'b0, MinGap} + {3'b000, lfsr[7:2]};
`else
  assign gap_value = {1'b0, MinGap};
`endif

  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) begin
      state   <= StIdle;
      lfsr    <= Seed;
      gap_cnt <= '0;
      occ     <= '0;
      types   <= '0;
      full    <= 1'b0;
    end else if (!Run) begin
      // The lane is stopped and cleared. Types and the LFSR are kept.
      state   <= StIdle;
      gap_cnt <= '0;
      occ     <= '0;
      full    <= 1'b0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      case (state)
        StIdle: state <= StSpawn;
        StSpawn: begin
          if (found) begin
            state   <= StGap;
            gap_cnt <= gap_value;
            for (int i = 0; i < NumSlots; i++) begin
              if (pick[i]) types[2*i +: 2] <= new_type;
            end
          end else begin
            state <= StBlocked;
            full  <= 1'b1;
          end
        end
        StGap: begin
          if (gap_cnt == 9'd1) state <= StSpawn;
          else                 gap_cnt <= gap_cnt - 9'd1;
        end
        StBlocked: begin
          if (!(&occ)) begin
            state <= StSpawn;
            full  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
      // pick is all-zero when no slot is free, so a blocked spawn writes nothing.
      // An exit on an unoccupied slot clears a bit that is already clear.
      occ <= (occ & ~CarExit) | ((state == StSpawn) ? pick : '0);
    end
  end

  assign SpawnEnable = occ;
  assign CarType     = types;
  assign LaneFull    = full;
  assign Speed       = LaneSpeed;
  assign FaceLeft    = LaneLeft;
  assign SpawnY      = LaneY;

endmodule

// File: tb/tb_lane_spawner.sv
module tb_lane_spawner;

  localparam int          NS   = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          GAP  = 40;

  logic          FrameClk = 1'b0;
  logic          ResetN;
  logic          Run;
  logic [NS-1:0] CarExit;
  logic [NS-1:0] SpawnEnable;
  logic [2*NS-1:0] CarType;
  logic [2:0]    Speed;
  logic          FaceLeft;
  logic [9:0]    SpawnY;
  logic          LaneFull;

  lane_spawner dut (
    .FrameClk(FrameClk),
    .ResetN(ResetN),
    .Run(Run),
    .CarExit(CarExit),
    .SpawnEnable(SpawnEnable),
    .CarType(CarType),
    .Speed(Speed),
    .FaceLeft(FaceLeft),
    .SpawnY(SpawnY),
    .LaneFull(LaneFull)
  );

  always #5 FrameClk = ~FrameClk;

  int tests = 0;
  int fails = 0;

  // Schedule-based reference: tracks absolute edge numbers for the next
  // spawn attempt rather than any state machine.
  logic [NS-1:0]   m_occ;
  logic [2*NS-1:0] m_type;
  logic [15:0]     m_lfsr;
  bit              m_idle;
  bit              m_blocked;
  int              m_attempt;
  int              edge_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic [15:0] poly_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;  // x^16 + x^14 + x^13 + x^11
    return r;
  endfunction

  function automatic bit has_type3(input logic [2*NS-1:0] t);
    bit r = 0;
    for (int i = 0; i < NS; i++) if (t[2*i +: 2] == 2'b11) r = 1;
    return r;
  endfunction

  task automatic model_reset();
    m_occ = '0; m_type = '0; m_lfsr = SEED;
    m_idle = 1; m_blocked = 0; m_attempt = -1; edge_n = 0;
  endtask

  task automatic model_edge(input logic run, input logic [NS-1:0] ex);
    logic [NS-1:0] nocc;
    int slot;
    int g;
    edge_n++;
    if (!run) begin
      m_occ = '0; m_idle = 1; m_blocked = 0; m_attempt = -1;
      return;
    end
    nocc = m_occ & ~ex;
    if (m_idle) begin
      m_idle = 0; m_attempt = edge_n + 1;
    end else if (m_blocked) begin
      if (m_occ != {NS{1'b1}}) begin m_blocked = 0; m_attempt = edge_n + 1; end
    end else if (edge_n == m_attempt) begin
      slot = -1;
      for (int i = NS - 1; i >= 0; i--) if (!m_occ[i]) slot = i;
      if (slot < 0) m_blocked = 1;
      else begin
        nocc[slot] = 1'b1;
        m_type[2*slot +: 2] = (m_lfsr[1:0] == 2'b11) ? 2'b00 : m_lfsr[1:0];
        g = GAP;
`ifdef LANE_SPAWNER_JITTER_EN
        g = g + int'(m_lfsr[7:2]);
`endif
        m_attempt = edge_n + g + 1;
      end
    end
    m_occ = nocc;
    m_lfsr = poly_next(m_lfsr);
  endtask

  task automatic tick();
    @(posedge FrameClk);
    model_edge(Run, CarExit);
    #1;
    check("spawn_enable", {28'd0, SpawnEnable}, {28'd0, m_occ});
    check("car_type", {24'd0, CarType}, {24'd0, m_type});
    check("lane_full", {31'd0, LaneFull}, {31'd0, m_blocked});
    check("type_range", {31'd0, has_type3(CarType)}, 32'd0);
  endtask

  initial begin
    int lo, hi, last_spawn, nspawn;
    bit hit;
    logic [NS-1:0] prev;

`ifdef LANE_SPAWNER_JITTER_EN
    lo = GAP + 1; hi = GAP + 64;
`else
    lo = GAP + 1; hi = GAP + 1;
`endif

    // Reset and start
    ResetN = 1'b0; Run = 1'b0; CarExit = '0;
    model_reset();
    #12;
    check("rst_spawn_enable", {28'd0, SpawnEnable}, 32'd0);
    check("rst_lane_full", {31'd0, LaneFull}, 32'd0);
    check("rst_car_type", {24'd0, CarType}, 32'd0);
    check("speed", {29'd0, Speed}, 32'd2);
    check("spawn_y", {22'd0, SpawnY}, 32'd0);
    check("face_left", {31'd0, FaceLeft}, 32'd0);
    ResetN = 1'b1; Run = 1'b1;

    tick();  // edge 1: IDLE -> SPAWN
    tick();  // edge 2: slot 0 filled
    check("first_spawn", {28'd0, SpawnEnable}, 32'h1);

    // Fill the lane until it blocks
    while (edge_n < 169) begin
      tick();
`ifndef LANE_SPAWNER_JITTER_EN
      if (edge_n == 43)  check("fill_slot1", {28'd0, SpawnEnable}, 32'h3);
      if (edge_n == 84)  check("fill_slot2", {28'd0, SpawnEnable}, 32'h7);
      if (edge_n == 125) check("fill_slot3", {28'd0, SpawnEnable}, 32'hF);
      if (edge_n == 166) begin
        check("full_flag", {31'd0, LaneFull}, 32'd1);
        check("full_enable", {28'd0, SpawnEnable}, 32'hF);
      end
`endif
    end

    // Refill after an exit from a full lane
    CarExit = 4'b0100;
    tick();  // edge 170
    CarExit = '0;
`ifndef LANE_SPAWNER_JITTER_EN
    check("exit_clears", {28'd0, SpawnEnable}, 32'hB);
`endif
    tick();  // edge 171
    check("full_drops", {31'd0, LaneFull}, 32'd0);
    tick();  // edge 172
`ifndef LANE_SPAWNER_JITTER_EN
    check("refilled", {28'd0, SpawnEnable}, 32'hF);
`endif
    for (int i = 0; i < 10; i++) tick();

    // Run drop mid-gap, then restart from slot 0
    Run = 1'b0;
    tick();
    check("run_drop_enable", {28'd0, SpawnEnable}, 32'd0);
    check("run_drop_full", {31'd0, LaneFull}, 32'd0);
    Run = 1'b1;
    tick();
    tick();
    check("restart_slot0", {28'd0, SpawnEnable}, 32'h1);

    // Exit/spawn collision: slot 1 exits on the edge that fills slot 3
    hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (m_occ == 4'b0111 && !m_idle && !m_blocked && m_attempt == edge_n + 1) begin
        CarExit = 4'b0010;
        hit = 1;
      end
      tick();
      CarExit = '0;
    end
    check("collision_reached", {31'd0, hit}, 32'd1);
    check("collision_enable", {28'd0, SpawnEnable}, 32'hD);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (SpawnEnable == 4'hF) hit = 1;
    end
    check("slot1_retaken", {31'd0, hit}, 32'd1);

    // Spawn spacing: every car exits right after appearing
    nspawn = 0; last_spawn = -1; prev = SpawnEnable;
    for (int i = 0; i < 51 * 110 && nspawn < 51; i++) begin
      CarExit = SpawnEnable;
      tick();
      if ((SpawnEnable & ~prev & ~CarExit) != 0 || (SpawnEnable & ~(prev & ~CarExit)) != 0) begin
        if (last_spawn >= 0) begin
          tests++;
          assert (edge_n - last_spawn >= lo && edge_n - last_spawn <= hi) else begin
            fails++;
            $error("FAIL spacing got=%0d exp=%0d..%0d", edge_n - last_spawn, lo, hi);
          end
        end
        last_spawn = edge_n;
        nspawn++;
      end
      prev = SpawnEnable;
    end
    CarExit = '0;
    check("spawn_count", nspawn, 32'd51);

    // Randomised traffic with occasional Run drops
    for (int i = 0; i < 2500; i++) begin
      CarExit = ($urandom_range(0, 9) == 0) ? NS'($urandom) : '0;
      Run = ($urandom_range(0, 199) != 0);
      tick();
    end
    CarExit = '0; Run = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Asynchronous reset between edges
    #2;
    ResetN = 1'b0;
    #1;
    model_reset();
    check("async_enable", {28'd0, SpawnEnable}, 32'd0);
    check("async_type", {24'd0, CarType}, 32'd0);
    check("async_full", {31'd0, LaneFull}, 32'd0);
    ResetN = 1'b1;
    tick();
    tick();
    check("post_reset_slot0", {28'd0, SpawnEnable}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
